radio_pkt_ctrl: RTL and testbench
=================================

# radio_pkt_ctrl

Packet-level transmit sequencer for the node radio. Buffers one outgoing packet (1..MAX_LEN bytes), powers the radio, drives its byte-wise `send`/`busy` handshake to emit a length byte plus payload, then opens a receive window for an acknowledge byte, retrying up to MAX_RETRY times. Sits between the sensor/application logic and the `radio` byte transceiver; it is the only driver of the radio's `enable`, `send`, `receive` and `tx_data`.

## Interface
- MAX_LEN, 16: payload buffer depth in bytes (power of two, 2..256)
- WAKE_CYCLES, 4: cycles radio_enable is held high before the first send of a packet
- ACK_TIMEOUT, 64: ACK_WAIT window length in cycles
- MAX_RETRY, 3: retransmissions after the first attempt
- ACK_BYTE, 8'hA5: acknowledge value
---
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  payload byte offered
- load_data  in  8  payload byte
- load_last  in  1  marks final byte of packet
- load_ready  out  1  controller accepts byte this cycle
- done  out  1  one-cycle pulse: packet acknowledged
- fail  out  1  one-cycle pulse: all attempts timed out
- attempts  out  $clog2(MAX_RETRY+2)  attempts used for current/last packet
- radio_enable  out  1  to radio enable
- radio_send  out  1  to radio send, one-cycle pulse
- radio_tx_data  out  8  to radio tx_data
- radio_busy  in  1  from radio busy
- radio_receive  out  1  to radio receive
- radio_rx_data  in  8  from radio rx_data
- radio_rx_valid  in  1  radio byte-received strobe, qualifies radio_rx_data

## Operation
- States: IDLE, LOAD, WAKE, SEND, SETTLE, WAIT_TX, ACK_WAIT, DONE, FAIL.
- IDLE/LOAD: load_ready = 1. Byte accepted when load_valid & load_ready; written at index wr_ptr, wr_ptr++. First accepted byte moves IDLE→LOAD. Accept with load_last, or acceptance of the MAX_LEN-th byte (forced last, truncation), stores len = wr_ptr+1 and goes to WAKE; attempts := 1.
- WAKE: radio_enable = 1 from here through ACK_WAIT; count WAKE_CYCLES, then SEND with byte index idx = 0.
- Frame: idx 0 transmits len (8 bits; MAX_LEN=256 sends 8'h00), idx k≥1 transmits buf[k-1]; frame length len+1 bytes.
- SEND: radio_tx_data = frame byte, radio_send = 1 for exactly this cycle → SETTLE (busy ignored one cycle) → WAIT_TX until radio_busy = 0. Then idx++; if idx = len+1 → ACK_WAIT else SEND. radio_tx_data holds its value until next SEND.
- ACK_WAIT: radio_receive = 1; timer counts ACK_TIMEOUT cycles. radio_rx_valid with radio_rx_data = ACK_BYTE → DONE. Other bytes ignored. Timeout: attempts ≤ MAX_RETRY → attempts++, idx = 0, SEND (no re-wake); else FAIL. Ack and final timer cycle coincide → ack wins.
- DONE / FAIL: pulse done / fail, radio_enable dropped, buffer cleared (wr_ptr = 0), → IDLE. attempts holds until next packet's first byte.
- radio_rx_valid outside ACK_WAIT ignored. load_valid outside IDLE/LOAD stalls (load_ready = 0).

## Timing
- Reset values: load_ready 0 while rst, 1 the cycle after release; done, fail, radio_enable, radio_send, radio_receive = 0; radio_tx_data = 8'h00; attempts = 0; state IDLE.
- rst mid-operation: immediate return to IDLE, buffer discarded, radio outputs low in same cycle (async).
- Last byte accept → WAKE next cycle; first radio_send pulse WAKE_CYCLES+1 cycles after last accept.
- Minimum per-byte spacing: SEND, SETTLE, ≥1 WAIT_TX = 3 cycles.
- Last byte's busy fall → radio_receive high next cycle. Timeout fires on the ACK_TIMEOUT-th ACK_WAIT cycle; retry SEND the cycle after.
- Ack accepted → done the next cycle, radio_enable low in that same cycle.

## Structure
- Shared package radio_pkg: state enum, ACK_BYTE default, frame-length width helper.
- One sub-module natural: radio_pkt_buf (MAX_LEN×8 single-port register file with write pointer, read by idx).

## Test plan
- Load 3 bytes 11,22,33 (last on 33), radio model acks 8'hA5 after 10 cycles → Tx frame 03,11,22,33; done pulse; attempts = 1; radio_enable low after.
- No ack, MAX_RETRY=3 → four identical frames, fail pulse after 4th timeout, attempts = 4, no done.
- Ack 8'h5A then 8'hA5 in window of attempt 2 → 8'h5A ignored; done; attempts = 2.
- 16 bytes without load_last (MAX_LEN=16) → 16th byte forced last; frame length byte 8'h10, 17 sends.
- Ack on exact timeout cycle → done, no retry frame.
- rst asserted during WAIT_TX of byte 2 → all radio outputs 0 immediately; next packet starts with wr_ptr 0 and attempts = 1.

Source files
------------

// File: rtl/radio_pkt_ctrl_pkg.sv
// Shared state encoding, default acknowledge value and sizing helpers
// for the radio packet transmit sequencer.
package radio_pkt_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAKE,
    ST_SEND,
    ST_SETTLE,
    ST_WAIT_TX,
    ST_ACK_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;

  // Frame length (payload + length byte) and the index into it need one bit
  // beyond the buffer address so that MAX_LEN and MAX_LEN+1 are representable.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic int att_w(input int max_retry);
    return $clog2(max_retry + 2);
  endfunction

endpackage

// File: rtl/radio_pkt_ctrl_if.sv
// Load-side handshake, status and radio byte-transceiver signals of the packet sequencer.
// master = the sequencer, slave = the application logic plus radio it talks to.
interface radio_pkt_ctrl_if #(
  parameter int MAX_RETRY = 3
);
  localparam int ATT_W = radio_pkt_ctrl_pkg::att_w(MAX_RETRY);

  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_last;
  logic             load_ready;
  logic             done;
  logic             fail;
  logic [ATT_W-1:0] attempts;
  logic             radio_enable;
  logic             radio_send;
  logic [7:0]       radio_tx_data;
  logic             radio_busy;
  logic             radio_receive;
  logic [7:0]       radio_rx_data;
  logic             radio_rx_valid;

  modport master (
    input  load_valid, load_data, load_last, radio_busy, radio_rx_data, radio_rx_valid,
    output load_ready, done, fail, attempts, radio_enable, radio_send, radio_tx_data,
           radio_receive
  );

  modport slave (
    output load_valid, load_data, load_last, radio_busy, radio_rx_data, radio_rx_valid,
    input  load_ready, done, fail, attempts, radio_enable, radio_send, radio_tx_data,
           radio_receive
  );

endinterface

// File: rtl/radio_pkt_ctrl_buf.sv
// Packet payload store: one write port with an auto-incrementing pointer,
// combinational read by index; clearing only rewinds the pointer.
module radio_pkt_ctrl_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_dat,
  input  logic                     i_clr,
  output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [7:0]               o_rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ptr <= '0;
    else if (i_clr)   r_ptr <= '0;
    else if (i_wr_en) r_ptr <= r_ptr + AW'(1);
  end

  assign o_wr_ptr = r_ptr;
  assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/radio_pkt_ctrl.sv
// Buffers one packet, wakes the radio, sends length byte + payload over the send/busy
// handshake and waits for an acknowledge, retrying on timeout; loading stalls while busy.
module radio_pkt_ctrl
  import radio_pkt_ctrl_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         WAKE_CYCLES = 4,
  parameter int         ACK_TIMEOUT = 64,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  radio_pkt_ctrl_if.master  io_bus
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = len_w(MAX_LEN);
  localparam int AT = att_w(MAX_RETRY);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        r_state, w_next;
  logic          r_alive;
  logic [LW-1:0] r_len, r_idx;
  logic [AT-1:0] r_att;
  logic [WW-1:0] r_wake;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_tx;
  logic [AW-1:0] w_wr_ptr, w_rd_idx;
  logic [7:0]    w_rd_dat, w_frame;
  logic          w_load, w_accept, w_last, w_clr, w_tx_done, w_ack, w_tmo, w_retry;

  assign w_load    = r_alive && (r_state == ST_IDLE || r_state == ST_LOAD);
  assign w_accept  = w_load && io_bus.load_valid;
  assign w_last    = w_accept && (io_bus.load_last || w_wr_ptr == AW'(MAX_LEN - 1));
  assign w_clr     = (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign w_tx_done = (r_state == ST_WAIT_TX) && !io_bus.radio_busy;
  assign w_ack     = (r_state == ST_ACK_WAIT) && io_bus.radio_rx_valid &&
                     (io_bus.radio_rx_data == ACK_BYTE);
  // An ack landing on the last window cycle takes priority over the timeout.
  assign w_tmo     = (r_state == ST_ACK_WAIT) && !w_ack && (r_timer == TW'(ACK_TIMEOUT - 1));
  assign w_retry   = r_att <= AT'(MAX_RETRY);

  // Frame byte 0 is the length (truncated to 8 bits), byte k is payload k-1.
  assign w_rd_idx  = AW'(r_idx - LW'(1));
  assign w_frame   = (r_idx == '0) ? 8'(r_len) : w_rd_dat;

  radio_pkt_ctrl_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_accept),
    .i_wr_dat (io_bus.load_data),
    .i_clr    (w_clr),
    .o_wr_ptr (w_wr_ptr),
    .i_rd_idx (w_rd_idx),
    .o_rd_dat (w_rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next                = r_state;
    io_bus.load_ready     = w_load;
    io_bus.done           = (r_state == ST_DONE);
    io_bus.fail           = (r_state == ST_FAIL);
    io_bus.attempts       = r_att;
    io_bus.radio_enable   = r_state inside {ST_WAKE, ST_SEND, ST_SETTLE, ST_WAIT_TX, ST_ACK_WAIT};
    io_bus.radio_send     = (r_state == ST_SEND);
    io_bus.radio_tx_data  = (r_state == ST_SEND) ? w_frame : r_tx;
    io_bus.radio_receive  = (r_state == ST_ACK_WAIT);
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_last)        w_next = ST_WAKE;
        else if (w_accept) w_next = ST_LOAD;
      end
      ST_WAKE:    if (r_wake == WW'(WAKE_CYCLES - 1)) w_next = ST_SEND;
      ST_SEND:    w_next = ST_SETTLE;
      ST_SETTLE:  w_next = ST_WAIT_TX;
      ST_WAIT_TX: if (w_tx_done) w_next = (r_idx == r_len) ? ST_ACK_WAIT : ST_SEND;
      ST_ACK_WAIT: begin
        if (w_ack)      w_next = ST_DONE;
        else if (w_tmo) w_next = w_retry ? ST_SEND : ST_FAIL;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive <= 1'b0;
      r_len   <= '0;
      r_idx   <= '0;
      r_att   <= '0;
      r_wake  <= '0;
      r_timer <= '0;
      r_tx    <= '0;
    end else begin
      r_alive <= 1'b1;
      r_wake  <= (r_state == ST_WAKE) ? r_wake + WW'(1) : '0;
      r_timer <= (r_state == ST_ACK_WAIT) ? r_timer + TW'(1) : '0;
      if (r_state == ST_SEND) r_tx <= w_frame;
      if (w_accept && r_state == ST_IDLE) r_att <= '0;
      if (w_last) begin
        r_len <= LW'(w_wr_ptr) + LW'(1);
        r_att <= AT'(1);
      end
      if (w_tmo && w_retry) r_att <= r_att + AT'(1);
      if (w_last || w_tmo)  r_idx <= '0;
      else if (w_tx_done)   r_idx <= r_idx + LW'(1);
    end
  end

endmodule

// File: tb/tb_radio_pkt_ctrl.sv
// Directed and randomized packets against a frame/attempt model; a concurrent
// radio model answers each send with a random-length busy and records the bytes.
module tb_radio_pkt_ctrl;
  localparam int         MAX_LEN     = 16;
  localparam int         WAKE_CYCLES = 4;
  localparam int         ACK_TIMEOUT = 64;
  localparam int         MAX_RETRY   = 3;
  localparam logic [7:0] ACK_BYTE    = 8'hA5;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] pay [MAX_LEN];
  int         plan [MAX_RETRY+1];
  logic [7:0] tx_q [$];
  int         send_c [$];
  int         t_acc;
  logic [7:0] junk_b;

  radio_pkt_ctrl_if #(.MAX_RETRY(MAX_RETRY)) bus ();

  radio_pkt_ctrl #(
    .MAX_LEN     (MAX_LEN),
    .WAKE_CYCLES (WAKE_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY),
    .ACK_BYTE    (ACK_BYTE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Radio byte transceiver: busy for 1..5 cycles starting in the send cycle.
  initial begin
    int bcnt;
    bcnt = 0;
    bus.radio_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bcnt = 0;
        bus.radio_busy = 1'b0;
      end else begin
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) bus.radio_busy = 1'b0;
        end
        if (bus.radio_send === 1'b1) begin
          tx_q.push_back(bus.radio_tx_data);
          send_c.push_back(int'($time / 10));
          bcnt = int'($urandom_range(1, 5));
          bus.radio_busy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pkt(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = pay[i];
      bus.load_last  = use_last && (i == n - 1);
      chk("load_ready", bus.load_ready, 1);
      t_acc = int'($time / 10);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("ready_low_wake", bus.load_ready, 0);
    chk("enable_wake", bus.radio_enable, 1);
  endtask

  task automatic run_packet(input int n, input bit use_last, input bit junk, input bit pre_ack);
    int         exp_att, k, cnt, mism, d, pos;
    bit         exp_ok;
    logic [7:0] len8, eb;
    len8    = 8'(n);
    exp_att = MAX_RETRY + 1;
    exp_ok  = 1'b0;
    for (int a = MAX_RETRY; a >= 0; a--) begin
      if (plan[a] >= 0 && plan[a] < ACK_TIMEOUT) begin
        exp_att = a + 1;
        exp_ok  = 1'b1;
      end
    end
    tx_q.delete();
    send_c.delete();
    load_pkt(n, use_last);
    for (int a = 0; a < exp_att; a++) begin
      k = 0;
      while (bus.radio_receive !== 1'b1 && k < 3000) begin
        if (pre_ack) begin
          bus.radio_rx_valid = 1'b1;
          bus.radio_rx_data  = ACK_BYTE;
        end
        tick();
        k++;
      end
      bus.radio_rx_valid = 1'b0;
      if (k >= 3000) begin
        chk("recv_wait", bus.radio_receive, 1);
        return;
      end
      chk("frames_before_ack", tx_q.size(), (n + 1) * (a + 1));
      if (a == 0 && send_c.size() > 0) chk("wake_latency", send_c[0] - t_acc, WAKE_CYCLES + 1);
      if (exp_ok && a == exp_att - 1) begin
        d = plan[a];
        for (int j = 0; j < d; j++) begin
          if (junk && j == d - 1) begin
            bus.radio_rx_valid = 1'b1;
            bus.radio_rx_data  = junk_b;
          end
          tick();
          bus.radio_rx_valid = 1'b0;
        end
        chk("recv_at_ack", bus.radio_receive, 1);
        bus.radio_rx_valid = 1'b1;
        bus.radio_rx_data  = ACK_BYTE;
        tick();
        bus.radio_rx_valid = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("enable_off_done", bus.radio_enable, 0);
        chk("fail_quiet", bus.fail, 0);
        chk("att_done", bus.attempts, exp_att);
        tick();
        chk("done_clear", bus.done, 0);
        chk("ready_idle", bus.load_ready, 1);
      end else begin
        cnt = 0;
        while (bus.radio_receive === 1'b1 && cnt < ACK_TIMEOUT + 8) begin
          if (junk) begin
            bus.radio_rx_valid = 1'b1;
            bus.radio_rx_data  = 8'($urandom_range(0, 255));
            if (bus.radio_rx_data == ACK_BYTE) bus.radio_rx_data = ~ACK_BYTE;
          end
          tick();
          cnt++;
        end
        bus.radio_rx_valid = 1'b0;
        chk("ack_window", cnt, ACK_TIMEOUT);
        if (a < MAX_RETRY) begin
          chk("retry_send", bus.radio_send, 1);
          chk("retry_len", bus.radio_tx_data, len8);
          chk("enable_retry", bus.radio_enable, 1);
        end else begin
          chk("fail_pulse", bus.fail, 1);
          chk("done_quiet", bus.done, 0);
          chk("att_fail", bus.attempts, exp_att);
          chk("enable_off_fail", bus.radio_enable, 0);
          tick();
          chk("fail_clear", bus.fail, 0);
        end
      end
    end
    repeat (3) tick();
    chk("frame_count", tx_q.size(), (n + 1) * exp_att);
    mism = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      pos = i % (n + 1);
      eb  = (pos == 0) ? len8 : pay[pos - 1];
      if (tx_q[i] !== eb) mism++;
    end
    chk("frame_bytes", mism, 0);
    chk("att_hold", bus.attempts, exp_att);
  endtask

  initial begin
    int k, n;
    bit use_last;
    rst                = 1'b1;
    bus.load_valid     = 1'b0;
    bus.load_data      = 8'h00;
    bus.load_last      = 1'b0;
    bus.radio_rx_valid = 1'b0;
    bus.radio_rx_data  = 8'h00;
    junk_b             = 8'h5A;

    // reset state
    tick();
    chk("rst_ready", bus.load_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_enable", bus.radio_enable, 0);
    chk("rst_send", bus.radio_send, 0);
    chk("rst_receive", bus.radio_receive, 0);
    chk("rst_txdata", bus.radio_tx_data, 0);
    chk("rst_attempts", bus.attempts, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.load_ready, 1);

    // basic 3-byte packet acked after 10 cycles
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    plan = '{10, -1, -1, -1};
    run_packet(3, 1'b1, 1'b0, 1'b0);

    // never acked: four frames then fail
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom_range(0, 255));
    plan = '{-1, -1, -1, -1};
    run_packet(3, 1'b1, 1'b1, 1'b0);

    // non-ack byte followed by ack in the second attempt
    pay[0] = 8'hC3; pay[1] = 8'h7E;
    junk_b = 8'h5A;
    plan = '{-1, 6, -1, -1};
    run_packet(2, 1'b1, 1'b1, 1'b0);

    // full buffer without load_last: truncation forces last
    for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'(i * 7 + 1);
    plan = '{20, -1, -1, -1};
    run_packet(MAX_LEN, 1'b0, 1'b0, 1'b1);

    // ack on the final window cycle wins over the timeout
    pay[0] = 8'h99;
    plan = '{ACK_TIMEOUT - 1, -1, -1, -1};
    run_packet(1, 1'b1, 1'b0, 1'b0);

    // reset while waiting for busy to drop on frame byte 2
    tx_q.delete();
    pay[0] = 8'h44; pay[1] = 8'h55; pay[2] = 8'h66;
    load_pkt(3, 1'b1);
    k = 0;
    while (tx_q.size() < 2 && k < 200) begin
      tick();
      k++;
    end
    chk("rst_reach_byte2", tx_q.size(), 2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_enable", bus.radio_enable, 0);
    chk("midrst_send", bus.radio_send, 0);
    chk("midrst_receive", bus.radio_receive, 0);
    chk("midrst_txdata", bus.radio_tx_data, 0);
    chk("midrst_attempts", bus.attempts, 0);
    tick();
    chk("midrst_ready", bus.load_ready, 0);
    rst = 1'b0;
    tick();
    chk("midrst_ready_rel", bus.load_ready, 1);
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom_range(0, 255));
    plan = '{3, -1, -1, -1};
    run_packet(4, 1'b1, 1'b0, 1'b0);

    // randomized packets
    for (int p = 0; p < 20; p++) begin
      n = int'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
      for (int a = 0; a <= MAX_RETRY; a++)
        plan[a] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, ACK_TIMEOUT - 1));
      use_last = (n < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      junk_b = 8'($urandom_range(0, 255));
      if (junk_b == ACK_BYTE) junk_b = 8'h00;
      run_packet(n, use_last, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
